exec_unit_rv32im: RTL and testbench

Parametrised next-generation execute stage for the RV32 core: single-cycle registered integer ALU (R- and I-type) plus iterative multiply/divide (M extension) behind a valid/ready issue handshake. It sits between decode/operand-read and writeback, consuming decoded opcode fields and operands, and honours the pipeline-wide `system_stall`.

---
 rtl/exec_pkg.sv | 64 ++++++
 rtl/exec_unit_rv32im_if.sv | 31 +++
 rtl/exec_muldiv_iter.sv | 122 ++++++++++++
 rtl/exec_unit_rv32im.sv | 200 ++++++++++++++++++++
 tb/tb_exec_unit_rv32im.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the RV32IM execute stage: opcode/funct encodings,
// FSM states, decoded-operation enum and a small classification helper.
package exec_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CALC     = 2'd1,
        ST_ALU_DONE = 2'd2,
        ST_M_DONE   = 2'd3
    } state_e;

    typedef enum logic [4:0] {
        OP_ADD     = 5'd0,
        OP_SUB     = 5'd1,
        OP_SLL     = 5'd2,
        OP_SLT     = 5'd3,
        OP_SLTU    = 5'd4,
        OP_XOR     = 5'd5,
        OP_SRL     = 5'd6,
        OP_SRA     = 5'd7,
        OP_OR      = 5'd8,
        OP_AND     = 5'd9,
        OP_MUL     = 5'd10,
        OP_MULH    = 5'd11,
        OP_MULHSU  = 5'd12,
        OP_MULHU   = 5'd13,
        OP_DIV     = 5'd14,
        OP_DIVU    = 5'd15,
        OP_REM     = 5'd16,
        OP_REMU    = 5'd17,
        OP_ILLEGAL = 5'd18
    } alu_op_e;

    function automatic logic is_muldiv(input alu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                          OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/exec_unit_rv32im_if.sv
// Issue/result bundle between operand-read, the execute stage and writeback.
interface exec_unit_rv32im_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 21
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [6:0]            instruction_type;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [IMM_WIDTH-1:0]  immediate;
    logic                  system_stall;
    logic [DATA_WIDTH-1:0] data_src1;
    logic [DATA_WIDTH-1:0] data_src2;
    logic [DATA_WIDTH-1:0] Execution_Result;
    logic                  Result_valid;
    logic                  illegal_op;
    logic                  busy;

    modport master (
        output issue_valid, instruction_type, funct3, funct7, immediate,
               system_stall, data_src1, data_src2,
        input  issue_ready, Execution_Result, Result_valid, illegal_op, busy
    );

    modport slave (
        input  issue_valid, instruction_type, funct3, funct7, immediate,
               system_stall, data_src1, data_src2,
        output issue_ready, Execution_Result, Result_valid, illegal_op, busy
    );
endinterface

// File: rtl/exec_muldiv_iter.sv
// Iterative M-extension datapath: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one step per unstalled clock, sign fix-up at the end.
module exec_muldiv_iter
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  alu_op_e               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int            CW        = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0]   hi_r, lo_r, m_r;
    logic                    neg_r, div_r, rem_r, want_hi_r, bzero_r, run_r;
    logic [CW-1:0]           cnt_r;

    logic                    signed_a_s, signed_b_s, neg_a_s, neg_b_s;
    logic                    div_op_s, rem_op_s, hi_op_s;
    logic [DATA_WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [DATA_WIDTH:0]     sum_s, rsh_s, diff_s;
    logic [DATA_WIDTH-1:0]   hi_nx_s, lo_nx_s;
    logic [2*DATA_WIDTH-1:0] prod_s;

    // Operand classification and magnitudes, used only on start.
    always_comb begin
        signed_a_s = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        signed_b_s = op inside {OP_MULH, OP_DIV, OP_REM};
        div_op_s   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        rem_op_s   = op inside {OP_REM, OP_REMU};
        hi_op_s    = op inside {OP_MULH, OP_MULHSU, OP_MULHU};
        neg_a_s    = signed_a_s & a[DATA_WIDTH-1];
        neg_b_s    = signed_b_s & b[DATA_WIDTH-1];
        mag_a_s    = neg_a_s ? -a : a;
        mag_b_s    = neg_b_s ? -b : b;
    end

    // One iteration: hi/lo hold {acc, multiplier} for MUL, {remainder, quotient} for DIV.
    always_comb begin
        sum_s  = {1'b0, hi_r} + ({(DATA_WIDTH+1){lo_r[0]}} & {1'b0, m_r});
        rsh_s  = {hi_r, lo_r[DATA_WIDTH-1]};
        diff_s = rsh_s - {1'b0, m_r};
        if (div_r) begin
            if (!diff_s[DATA_WIDTH]) begin
                hi_nx_s = diff_s[DATA_WIDTH-1:0];
                lo_nx_s = {lo_r[DATA_WIDTH-2:0], 1'b1};
            end else begin
                hi_nx_s = rsh_s[DATA_WIDTH-1:0];
                lo_nx_s = {lo_r[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nx_s = sum_s[DATA_WIDTH:1];
            lo_nx_s = {sum_s[0], lo_r[DATA_WIDTH-1:1]};
        end
    end

    // Result reflects the step in flight so it is final on the last step's edge.
    always_comb begin
        prod_s = neg_r ? -{hi_nx_s, lo_nx_s} : {hi_nx_s, lo_nx_s};
        result = '0;
        if (!div_r) begin
            if (want_hi_r) begin
                result = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            end else begin
                result = prod_s[DATA_WIDTH-1:0];
            end
        end else if (rem_r) begin
            result = neg_r ? -hi_nx_s : hi_nx_s;
        end else if (bzero_r) begin
            result = '1;
        end else begin
            result = neg_r ? -lo_nx_s : lo_nx_s;
        end
    end

    assign done = run_r && (cnt_r == LAST_STEP);

    // Operand load on start, then one step per unstalled edge until the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r      <= '0;
            lo_r      <= '0;
            m_r       <= '0;
            neg_r     <= 1'b0;
            div_r     <= 1'b0;
            rem_r     <= 1'b0;
            want_hi_r <= 1'b0;
            bzero_r   <= 1'b0;
            run_r     <= 1'b0;
            cnt_r     <= '0;
        end else if (!stall) begin
            if (start) begin
                m_r       <= div_op_s ? mag_b_s : mag_a_s;
                hi_r      <= '0;
                lo_r      <= div_op_s ? mag_a_s : mag_b_s;
                neg_r     <= rem_op_s ? neg_a_s : (neg_a_s ^ neg_b_s);
                div_r     <= div_op_s;
                rem_r     <= rem_op_s;
                want_hi_r <= hi_op_s;
                bzero_r   <= (b == '0);
                run_r     <= 1'b1;
                cnt_r     <= '0;
            end else if (run_r) begin
                hi_r <= hi_nx_s;
                lo_r <= lo_nx_s;
                if (cnt_r == LAST_STEP) begin
                    run_r <= 1'b0;
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/exec_unit_rv32im.sv
// RV32IM execute stage: decode, single-cycle ALU, iterative M unit and the
// issue/result FSM with registered outputs, frozen by system_stall.
module exec_unit_rv32im
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 21
) (
    input  logic              clk,
    input  logic              reset,
    exec_unit_rv32im_if.slave bus
);
    localparam int             SHW      = $clog2(DATA_WIDTH);
    localparam logic [SHW-1:0] CNT_LOAD = SHW'(DATA_WIDTH - 1);

    state_e                state_r, state_nx_s;
    logic [SHW-1:0]        cnt_r, cnt_nx_s;
    logic [DATA_WIDTH-1:0] result_r, result_nx_s;
    logic                  illegal_r, illegal_nx_s, valid_r, busy_r;

    alu_op_e               op_s;
    logic                  use_src2_s, issue_ready_s, accept_s, md_start_s, md_done_s;
    logic [DATA_WIDTH-1:0] imm_ext_s, op2_s, alu_res_s, md_result_s;
    logic [SHW-1:0]        shamt_s;

    assign imm_ext_s     = DATA_WIDTH'($signed(bus.immediate[11:0]));
    assign issue_ready_s = (state_r == ST_IDLE) && !bus.system_stall;
    assign accept_s      = bus.issue_valid && issue_ready_s;

    // Opcode/funct decode into a single operation code.
    always_comb begin
        op_s       = OP_ILLEGAL;
        use_src2_s = 1'b0;
        case (bus.instruction_type)
            OPC_OP: begin
                use_src2_s = 1'b1;
                case (bus.funct7)
                    F7_BASE: begin
                        case (bus.funct3)
                            F3_ADD_SUB: op_s = OP_ADD;
                            F3_SLL:     op_s = OP_SLL;
                            F3_SLT:     op_s = OP_SLT;
                            F3_SLTU:    op_s = OP_SLTU;
                            F3_XOR:     op_s = OP_XOR;
                            F3_SRL_SRA: op_s = OP_SRL;
                            F3_OR:      op_s = OP_OR;
                            F3_AND:     op_s = OP_AND;
                            default:    op_s = OP_ILLEGAL;
                        endcase
                    end
                    F7_ALT: begin
                        case (bus.funct3)
                            F3_ADD_SUB: op_s = OP_SUB;
                            F3_SRL_SRA: op_s = OP_SRA;
                            default:    op_s = OP_ILLEGAL;
                        endcase
                    end
                    F7_MULDIV: begin
                        case (bus.funct3)
                            F3_MUL:    op_s = OP_MUL;
                            F3_MULH:   op_s = OP_MULH;
                            F3_MULHSU: op_s = OP_MULHSU;
                            F3_MULHU:  op_s = OP_MULHU;
                            F3_DIV:    op_s = OP_DIV;
                            F3_DIVU:   op_s = OP_DIVU;
                            F3_REM:    op_s = OP_REM;
                            F3_REMU:   op_s = OP_REMU;
                            default:   op_s = OP_ILLEGAL;
                        endcase
                    end
                    default: op_s = OP_ILLEGAL;
                endcase
            end
            OPC_OP_IMM: begin
                case (bus.funct3)
                    F3_ADD_SUB: op_s = OP_ADD;
                    F3_SLL:     op_s = OP_SLL;
                    F3_SLT:     op_s = OP_SLT;
                    F3_SLTU:    op_s = OP_SLTU;
                    F3_XOR:     op_s = OP_XOR;
                    F3_SRL_SRA: op_s = bus.immediate[10] ? OP_SRA : OP_SRL;
                    F3_OR:      op_s = OP_OR;
                    F3_AND:     op_s = OP_AND;
                    default:    op_s = OP_ILLEGAL;
                endcase
            end
            default: op_s = OP_ILLEGAL;
        endcase
    end

    // Single-cycle integer ALU; shift amounts come from the low bits of operand 2.
    always_comb begin
        if (use_src2_s) begin
            op2_s = bus.data_src2;
        end else begin
            op2_s = imm_ext_s;
        end
        shamt_s = op2_s[SHW-1:0];
        case (op_s)
            OP_ADD:  alu_res_s = bus.data_src1 + op2_s;
            OP_SUB:  alu_res_s = bus.data_src1 - op2_s;
            OP_SLL:  alu_res_s = bus.data_src1 << shamt_s;
            OP_SLT:  alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.data_src1) < $signed(op2_s))};
            OP_SLTU: alu_res_s = {{(DATA_WIDTH-1){1'b0}}, (bus.data_src1 < op2_s)};
            OP_XOR:  alu_res_s = bus.data_src1 ^ op2_s;
            OP_SRL:  alu_res_s = bus.data_src1 >> shamt_s;
            OP_SRA:  alu_res_s = $signed(bus.data_src1) >>> shamt_s;
            OP_OR:   alu_res_s = bus.data_src1 | op2_s;
            OP_AND:  alu_res_s = bus.data_src1 & op2_s;
            default: alu_res_s = '0;
        endcase
    end

    exec_muldiv_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_s),
        .op     (op_s),
        .a      (bus.data_src1),
        .b      (bus.data_src2),
        .stall  (bus.system_stall),
        .done   (md_done_s),
        .result (md_result_s)
    );

    // Next-state, iteration counter and result selection.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        result_nx_s  = result_r;
        illegal_nx_s = illegal_r;
        md_start_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_muldiv(op_s)) begin
                        state_nx_s   = ST_CALC;
                        cnt_nx_s     = CNT_LOAD;
                        md_start_s   = 1'b1;
                        illegal_nx_s = 1'b0;
                    end else begin
                        state_nx_s   = ST_ALU_DONE;
                        result_nx_s  = alu_res_s;
                        illegal_nx_s = (op_s == OP_ILLEGAL);
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r != '0) begin
                    cnt_nx_s = cnt_r - 1'b1;
                end else begin
                    state_nx_s = ST_M_DONE;
                    // A datapath out of step with the counter yields zero, never stale data.
                    if (md_done_s) begin
                        result_nx_s = md_result_s;
                    end else begin
                        result_nx_s = '0;
                    end
                end
            end
            ST_ALU_DONE, ST_M_DONE: begin
                state_nx_s   = ST_IDLE;
                illegal_nx_s = 1'b0;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State and output registers; reset wins over stall, stall freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            result_r  <= '0;
            illegal_r <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else if (!bus.system_stall) begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            result_r  <= result_nx_s;
            illegal_r <= illegal_nx_s;
            valid_r   <= (state_nx_s == ST_ALU_DONE) || (state_nx_s == ST_M_DONE);
            busy_r    <= (state_nx_s == ST_CALC);
        end
    end

    assign bus.issue_ready      = issue_ready_s;
    assign bus.Execution_Result = result_r;
    assign bus.Result_valid     = valid_r;
    assign bus.illegal_op       = illegal_r;
    assign bus.busy             = busy_r;
endmodule

// File: tb/tb_exec_unit_rv32im.sv
// Self-checking bench for exec_unit_rv32im: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_exec_unit_rv32im;
    logic clk;
    logic reset;
    int   checks_cnt;
    int   errors_cnt;

    exec_unit_rv32im_if #(.DATA_WIDTH(32), .IMM_WIDTH(21)) bus ();

    exec_unit_rv32im #(.DATA_WIDTH(32), .IMM_WIDTH(21)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: result straight from the RV32IM arithmetic definitions.
    function automatic void model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [20:0] imm, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output bit ill, output bit mop);
        longint sa, sb, ua, ub, p;
        longint unsigned pu;
        logic [31:0] op2;
        logic signed [31:0] sra;
        bit alt, alu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        res = 32'h0; ill = 1'b0; mop = 1'b0; alu = 1'b0; alt = 1'b0; op2 = b;
        if (opc == 7'b0110011 && f7 == 7'b0000001) begin
            mop = 1'b1;
            case (f3)
                3'd0: begin p = sa * sb; res = p[31:0]; end
                3'd1: begin p = sa * sb; res = p[63:32]; end
                3'd2: begin p = sa * ub; res = p[63:32]; end
                3'd3: begin pu = ua * ub; res = pu[63:32]; end
                3'd4: if (b == 32'h0) res = 32'hFFFF_FFFF; else begin p = sa / sb; res = p[31:0]; end
                3'd5: if (b == 32'h0) res = 32'hFFFF_FFFF; else begin p = ua / ub; res = p[31:0]; end
                3'd6: if (b == 32'h0) res = a; else begin p = sa % sb; res = p[31:0]; end
                default: if (b == 32'h0) res = a; else begin p = ua % ub; res = p[31:0]; end
            endcase
        end else if (opc == 7'b0110011 &&
                     (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)))) begin
            alu = 1'b1; alt = (f7 == 7'b0100000); op2 = b;
        end else if (opc == 7'b0010011) begin
            alu = 1'b1; op2 = {{20{imm[11]}}, imm[11:0]}; alt = (f3 == 3'd5) && imm[10];
        end else begin
            ill = 1'b1;
        end
        if (alu) begin
            case (f3)
                3'd0: res = alt ? a - op2 : a + op2;
                3'd1: res = a << op2[4:0];
                3'd2: res = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
                3'd3: res = (a < op2) ? 32'd1 : 32'd0;
                3'd4: res = a ^ op2;
                3'd5: begin sra = $signed(a) >>> op2[4:0]; res = alt ? sra : (a >> op2[4:0]); end
                3'd6: res = a | op2;
                default: res = a & op2;
            endcase
        end
    endfunction

    // Issue one op, optionally stalling at a given cycle count after accept, and check it.
    task automatic do_op(input string tag, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [20:0] imm, input logic [31:0] a, input logic [31:0] b,
                         input int stall_at, input int stall_len, input bit use_want, input logic [31:0] want);
        logic [31:0] exp_res;
        bit exp_ill, mop, seen, bad, held_bad;
        int base_lat, exp_lat, exp_vlen, lat, vcnt;
        model(opc, f3, f7, imm, a, b, exp_res, exp_ill, mop);
        if (use_want) exp_res = want;
        base_lat = mop ? 33 : 1;
        exp_lat  = base_lat;
        exp_vlen = 1;
        if (stall_len > 0 && stall_at < base_lat) exp_lat = base_lat + stall_len;
        else if (stall_len > 0 && stall_at == base_lat) exp_vlen = 1 + stall_len;
        @(negedge clk);
        bus.instruction_type = opc; bus.funct3 = f3; bus.funct7 = f7; bus.immediate = imm;
        bus.data_src1 = a; bus.data_src2 = b; bus.issue_valid = 1'b1;
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
        lat = 0; seen = 1'b0; bad = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.Result_valid) seen = 1'b1;
            else if (bus.busy !== mop || bus.issue_ready !== 1'b0) bad = 1'b1;
            if (stall_len > 0 && lat == stall_at) bus.system_stall = 1'b1;
            else if (stall_len > 0 && lat == stall_at + stall_len) bus.system_stall = 1'b0;
        end
        check_val({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, ".result"}, bus.Execution_Result, exp_res);
        check_val({tag, ".illegal"}, {31'h0, bus.illegal_op}, {31'h0, exp_ill});
        check_val({tag, ".busy_ready"}, {31'h0, bad}, 32'h0);
        vcnt = seen ? 1 : 0;
        held_bad = 1'b0;
        while (seen && lat < 400) begin
            @(negedge clk);
            lat++;
            if (stall_len > 0 && lat == stall_at + stall_len) bus.system_stall = 1'b0;
            if (!bus.Result_valid) break;
            vcnt++;
            if (bus.Execution_Result !== exp_res) held_bad = 1'b1;
        end
        bus.system_stall = 1'b0;
        check_val({tag, ".valid_len"}, 32'(vcnt), 32'(exp_vlen));
        check_val({tag, ".held_data"}, {31'h0, held_bad}, 32'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [31:0] a, b;
        bit bad;
        checks_cnt = 0; errors_cnt = 0;
        clk = 1'b0; reset = 1'b1;
        bus.issue_valid = 1'b0; bus.instruction_type = 7'h0; bus.funct3 = 3'h0; bus.funct7 = 7'h0;
        bus.immediate = 21'h0; bus.system_stall = 1'b0; bus.data_src1 = 32'h0; bus.data_src2 = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst.result", bus.Execution_Result, 32'h0);
        check_val("rst.valid", {31'h0, bus.Result_valid}, 32'h0);
        check_val("rst.illegal", {31'h0, bus.illegal_op}, 32'h0);
        check_val("rst.busy", {31'h0, bus.busy}, 32'h0);
        check_val("rst.ready", {31'h0, bus.issue_ready}, 32'h1);

        do_op("add",    7'b0110011, 3'd0, 7'h00, 21'h0,   32'h10, 32'h20, 0, 0, 1'b1, 32'h30);
        do_op("sub",    7'b0110011, 3'd0, 7'h20, 21'h0,   32'h30, 32'h10, 0, 0, 1'b1, 32'h20);
        do_op("srai",   7'b0010011, 3'd5, 7'h00, 21'h404, 32'hF000_0000, 32'h0, 0, 0, 1'b1, 32'hFF00_0000);
        do_op("sltu",   7'b0110011, 3'd3, 7'h00, 21'h0,   32'h1, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'h1);
        do_op("slt",    7'b0110011, 3'd2, 7'h00, 21'h0,   32'h1, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'h0);
        do_op("mul",    7'b0110011, 3'd0, 7'h01, 21'h0,   32'h7, 32'hFFFF_FFFD, 0, 0, 1'b1, 32'hFFFF_FFEB);
        do_op("mulh",   7'b0110011, 3'd1, 7'h01, 21'h0,   32'h7, 32'hFFFF_FFFD, 0, 0, 1'b1, 32'hFFFF_FFFF);
        do_op("mulhu",  7'b0110011, 3'd3, 7'h01, 21'h0,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'hFFFF_FFFE);
        do_op("div_ov", 7'b0110011, 3'd4, 7'h01, 21'h0,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'h8000_0000);
        do_op("rem_ov", 7'b0110011, 3'd6, 7'h01, 21'h0,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'h0);
        do_op("divu_0", 7'b0110011, 3'd5, 7'h01, 21'h0,   32'h5, 32'h0, 0, 0, 1'b1, 32'hFFFF_FFFF);
        do_op("remu_0", 7'b0110011, 3'd7, 7'h01, 21'h0,   32'h5, 32'h0, 0, 0, 1'b1, 32'h5);
        do_op("div_neg", 7'b0110011, 3'd4, 7'h01, 21'h0,  32'hFFFF_FFF9, 32'h2, 0, 0, 1'b1, 32'hFFFF_FFFD);
        do_op("rem_neg", 7'b0110011, 3'd6, 7'h01, 21'h0,  32'hFFFF_FFF9, 32'h2, 0, 0, 1'b1, 32'hFFFF_FFFF);
        do_op("div_stall", 7'b0110011, 3'd4, 7'h01, 21'h0, 32'hFFFF_FFF9, 32'h2, 10, 5, 1'b1, 32'hFFFF_FFFD);
        do_op("valid_stall", 7'b0110011, 3'd0, 7'h00, 21'h0, 32'h10, 32'h20, 1, 3, 1'b1, 32'h30);
        do_op("illegal", 7'b0000000, 3'd0, 7'h00, 21'h0,  32'h1234, 32'h5678, 0, 0, 1'b1, 32'h0);

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        bus.instruction_type = 7'b0110011; bus.funct3 = 3'd0; bus.funct7 = 7'h01;
        bus.data_src1 = 32'h7; bus.data_src2 = 32'hFFFF_FFFD; bus.issue_valid = 1'b1;
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("mid_rst.valid", {31'h0, bus.Result_valid}, 32'h0);
        check_val("mid_rst.busy", {31'h0, bus.busy}, 32'h0);
        check_val("mid_rst.ready", {31'h0, bus.issue_ready}, 32'h1);
        check_val("mid_rst.result", bus.Execution_Result, 32'h0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Result_valid) bad = 1'b1;
        end
        check_val("mid_rst.no_late_result", {31'h0, bad}, 32'h0);

        for (int n = 0; n < 150; n++) begin
            a  = pick();
            b  = pick();
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: begin opc = 7'b0110011; f7 = 7'h00; end
                1: begin opc = 7'b0110011; f7 = 7'h20; end
                2: begin opc = 7'b0110011; f7 = 7'h01; end
                3: begin opc = 7'b0010011; f7 = 7'($urandom); end
                default: begin
                    opc = 7'($urandom);
                    if (opc == 7'b0010011) opc = 7'b0010111;
                    f7 = 7'($urandom);
                    if (opc == 7'b0110011 && (f7 == 7'h00 || f7 == 7'h01 || f7 == 7'h20)) f7 = 7'h7F;
                end
            endcase
            do_op("rnd", opc, f3, f7, 21'($urandom), a, b, 0, 0, 1'b0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
